// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_engine convolution slice.
// Array typedefs describe the default tile geometry; the engine sizes its own storage from its parameters.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    MAC   = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } conv_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_ROWS    = 8;
  localparam int DEF_N_COLUMNS = 8;
  localparam int DEF_K         = 3;

  // Wide enough for K*K full-precision products, so the sum can never overflow.
  function automatic int acc_width(input int width, input int k);
    return 2 * width + $clog2(k * k);
  endfunction

  typedef logic signed [DEF_WIDTH-1:0] kern_arr_t [DEF_K][DEF_K];
  typedef logic signed [DEF_WIDTH-1:0] img_arr_t  [DEF_N_ROWS][DEF_N_COLUMNS];

endpackage

// File: rtl/conv_engine_mac.sv
// Signed multiply-accumulate: clr loads the first product, later enabled cycles add to it.
module mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = clr ? prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_engine.sv
// Single-channel valid-only 2D convolution: loads a KxK kernel and an image tile from memory,
// then streams one MAC-computed pixel per valid/ready handshake (transfer when out_valid & out_ready at clk).
module conv_engine import conv_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int N_ROWS     = 8,
  parameter int N_COLUMNS  = 8,
  parameter int K          = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = acc_width(WIDTH, K)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [WIDTH-1:0]              mem_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [$clog2(N_ROWS)-1:0]     out_row,
  output logic [$clog2(N_COLUMNS)-1:0]  out_col,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output conv_state_t                   dbg_state
);

  localparam int RW     = $clog2(N_ROWS);
  localparam int CW     = $clog2(N_COLUMNS);
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int NREADS = K * K + N_ROWS * N_COLUMNS;
  localparam int CNT_W  = $clog2(NREADS + 1);

  conv_state_t             state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        rd_cnt_q;
  logic                    rd_en_q, rd_vld_q, ld_img_q;
  logic [RW-1:0]           ld_i_q, r_q, win_r;
  logic [CW-1:0]           ld_j_q, c_q, win_c;
  logic [KW-1:0]           i_q, j_q;
  logic                    out_valid_q, out_last_q, busy_q, done_q;
  logic signed [WIDTH-1:0] kern_q [K][K];
  logic signed [WIDTH-1:0] img_q  [N_ROWS][N_COLUMNS];
  logic signed [ACC_WIDTH-1:0] acc;

  assign win_r = r_q + RW'(i_q);
  assign win_c = c_q + CW'(j_q);

  // Read data lags its strobe by one cycle, so capture is driven by the delayed strobe rd_vld_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++) kern_q[a][b] <= '0;
      for (int a = 0; a < N_ROWS; a++)
        for (int b = 0; b < N_COLUMNS; b++) img_q[a][b] <= '0;
    end else if (rd_vld_q) begin
      if (!ld_img_q) kern_q[i_q][j_q] <= mem_rd_data;
      else           img_q[ld_i_q][ld_j_q] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;  addr_q <= '0;  rd_cnt_q <= '0;
      rd_en_q <= 1'b0;  rd_vld_q <= 1'b0;  ld_img_q <= 1'b0;
      ld_i_q <= '0;  ld_j_q <= '0;  r_q <= '0;  c_q <= '0;  i_q <= '0;  j_q <= '0;
      out_valid_q <= 1'b0;  out_last_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_q;
      // i_q/j_q walk the kernel during the load, then index the window during MAC.
      if (rd_vld_q) begin
        if (!ld_img_q) begin
          if (j_q == KW'(K-1)) begin
            j_q <= '0;
            if (i_q == KW'(K-1)) begin i_q <= '0; ld_img_q <= 1'b1; end
            else i_q <= i_q + 1'b1;
          end else j_q <= j_q + 1'b1;
        end else begin
          if (ld_j_q == CW'(N_COLUMNS-1)) begin
            ld_j_q <= '0;
            ld_i_q <= (ld_i_q == RW'(N_ROWS-1)) ? '0 : ld_i_q + 1'b1;
          end else ld_j_q <= ld_j_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: if (start) begin
          addr_q <= base_addr;  rd_cnt_q <= '0;  rd_en_q <= 1'b1;  busy_q <= 1'b1;
          ld_img_q <= 1'b0;  ld_i_q <= '0;  ld_j_q <= '0;
          i_q <= '0;  j_q <= '0;  r_q <= '0;  c_q <= '0;
          state_q <= LOAD;
        end
        LOAD: begin
          addr_q   <= addr_q + 1'b1;
          rd_cnt_q <= rd_cnt_q + 1'b1;
          if (rd_cnt_q == CNT_W'(NREADS-1)) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: state_q <= MAC;
        MAC: begin
          if (j_q == KW'(K-1)) begin
            j_q <= '0;
            if (i_q == KW'(K-1)) begin
              i_q <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= (r_q == RW'(N_ROWS-K)) && (c_q == CW'(N_COLUMNS-K));
              state_q     <= OUT;
            end else i_q <= i_q + 1'b1;
          end else j_q <= j_q + 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          state_q     <= MAC;
          if (c_q == CW'(N_COLUMNS-K)) begin
            c_q <= '0;
            if (r_q == RW'(N_ROWS-K)) begin
              r_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b1;  state_q <= FIN;
            end else r_q <= r_q + 1'b1;
          end else c_q <= c_q + 1'b1;
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mac_unit #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr ((state_q == MAC) && (i_q == '0) && (j_q == '0)),
    .en  (state_q == MAC),
    .a   (kern_q[i_q][j_q]),
    .b   (img_q[win_r][win_c]),
    .acc (acc)
  );

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc;
  assign out_row   = r_q;
  assign out_col   = c_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
Parametrised single-channel 2D convolution engine. It fetches a KxK signed kernel followed by an N_ROWS x N_COLUMNS signed image tile from a synchronous read-only memory port into local register arrays. It then computes every valid (no-padding) output pixel with a sequential multiply-accumulate. Results stream out one pixel at a time over a valid/ready handshake. It supersedes the fixed-size load-and-hold convolutor top and sits between the weight/image RAM and downstream activation logic.

Parameters:
WIDTH, 8, bit width of kernel and image elements (signed two's complement)
N_ROWS, 8, image tile rows
N_COLUMNS, 8, image tile columns
K, 3, kernel edge; must satisfy 1 <= K <= min(N_ROWS, N_COLUMNS)
ADDR_WIDTH, 10, memory address width
ACC_WIDTH, 2*WIDTH+$clog2(K*K), accumulator/output width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a job; sampled only in IDLE
base_addr  input  ADDR_WIDTH  address of first kernel word; sampled with start
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory read address
mem_rd_data  input  WIDTH  read data, valid exactly 1 cycle after mem_rd_en
out_valid  output  1  out_data/out_row/out_col/out_last are valid
out_ready  input  1  downstream accepts the current output
out_data  output  ACC_WIDTH  signed convolution result
out_row  output  $clog2(N_ROWS)  output pixel row index
out_col  output  $clog2(N_COLUMNS)  output pixel column index
out_last  output  1  marks the final pixel of the job
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (asynchronous, rst=0): state IDLE. All outputs 0. Local arrays, accumulator and counters cleared. Reset mid-job aborts the job immediately; no done pulse.
- Memory layout, row-major: kernel words at base_addr .. base_addr+K*K-1, then image words, contiguous. Addresses wrap modulo 2^ADDR_WIDTH.
- FSM states: IDLE, LOAD, DRAIN, MAC, OUT, FIN.
- IDLE: start=1 at edge t latches base_addr and enters LOAD. busy=1 from t+1.
- LOAD: mem_rd_en=1 for exactly K*K+N_ROWS*N_COLUMNS consecutive cycles, with mem_addr incrementing by 1 each cycle. Each mem_rd_data word is captured one cycle after its read into the kernel array, then the image array, in order.
- DRAIN: one cycle with mem_rd_en=0 to capture the final word, then MAC.
- MAC: exactly K*K cycles per output pixel. The accumulator clears on the first cycle and adds kernel[i][j]*image[r+i][c+j] each cycle.
- Arithmetic: full-precision signed multiply, sign-extended to ACC_WIDTH. No saturation is needed because overflow is impossible by construction.
- OUT: out_valid=1 with registered out_data, out_row=r, out_col=c, and out_last=1 only for r=N_ROWS-K, c=N_COLUMNS-K.
  - All output fields hold stable while out_valid=1 and out_ready=0.
  - A handshake is out_valid & out_ready at an edge. It advances c, then r (raster order), and returns to MAC, or to FIN after the last pixel.
  - out_ready has no effect outside OUT.
- FIN: done=1 for one cycle; busy=0 in the same cycle; next state IDLE.
- start while busy: ignored entirely. base_addr is not re-sampled.
- Output count per job: (N_ROWS-K+1)*(N_COLUMNS-K+1).
- Minimum job latency, start edge to done: 1 + reads + 1 + outputs*(K*K+1) + 1 cycles, with out_ready tied high.
- K=1 degenerate case: one MAC cycle per output; the output is the element-wise product.

Decomposition:
- Shared package conv_pkg:
  - state enum conv_state_t.
  - function acc_width(WIDTH,K).
  - typedefs for the kernel array [K][K][WIDTH] and the image array [N_ROWS][N_COLUMNS][WIDTH].
- Sub-module mac_unit (WIDTH, ACC_WIDTH):
  - Inputs: clk, rst, clr, en, a, b.
  - Output: acc.
  - Signed multiply-accumulate with synchronous clear-on-first-term.
- All remaining logic (FSM, address counter, load indices, window indices, output register) lives in conv_engine.

Test Plan:
- Bench parameters N_ROWS=N_COLUMNS=4, K=3, WIDTH=8, ADDR_WIDTH=10, out_ready=1, kernel all 1, image 1..16 -> outputs 54, 63, 90, 99 at (0,0),(0,1),(1,0),(1,1); out_last only on 99; 25 reads at base..base+24; single done pulse.
- Kernel centre=-1 (0xFF), others 0, image all 127 -> four outputs equal to -127 (0xFFF81 in 20 bits).
- Kernel and image all -128 -> every output +147456. Confirms no overflow in ACC_WIDTH=20.
- out_ready held low 5 cycles during the first OUT -> out_valid stays 1, out_data=54 stable, no index advance; completes normally once ready rises.
- base_addr=1020 -> mem_addr sequence 1020..1023, 0..20. Results match the non-wrapped run.
- Reset asserted mid-MAC, then start pulsed during busy on the following job -> all outputs 0 at reset with no done pulse; the mid-job start is ignored and only one done pulse occurs per accepted start.
